// File: rtl/doodle_landing_detector_if.sv
// Bus between the game logic and doodle_landing_detector.
// master: game side (drives frame counter, platform field, doodle state).
// slave : detector side (drives scan results).
interface doodle_landing_detector_if #(
  parameter int N_PLATFORMS = 93,
  parameter int FC_W        = 21
);
  logic [FC_W-1:0]                          fps_counter;
  logic signed [N_PLATFORMS-1:0][1:0][10:0] platforms;
  logic [N_PLATFORMS-1:0]                   platform_activation;
  logic [10:0]                              doodle_x;
  logic [9:0]                               doodle_y;
  logic                                     doodle_falling;
  logic                                     move_collision;
  logic                                     landed;
  logic [6:0]                               hit_index;
  logic signed [10:0]                       land_y;
  logic                                     busy;

  modport master (
    output fps_counter, platforms, platform_activation,
           doodle_x, doodle_y, doodle_falling,
    input  move_collision, landed, hit_index, land_y, busy
  );

  modport slave (
    input  fps_counter, platforms, platform_activation,
           doodle_x, doodle_y, doodle_falling,
    output move_collision, landed, hit_index, land_y, busy
  );
endinterface

// File: rtl/doodle_landing_detector.sv
// doodle_landing_detector: per-frame scan of the platform field for the
// first active platform the falling doodle has landed on. One slot per
// clock through a two-stage compare pipeline; lowest index wins.
// Optional macro LANDING_STATS_EN adds a saturating landing_count output.
// The frame tick is fps_counter all ones; its width is set by the bus
// instance ($clog2(CLK/FPS)+1).
module doodle_landing_detector #(
  parameter int FPS         = 60,
  parameter int CLK         = 50_000_000,
  parameter int N_PLATFORMS = 93,
  parameter int PLATFORM_W  = 100,
  parameter int DOODLE_W    = 80,
  parameter int DOODLE_H    = 80,
  parameter int LAND_TOL    = 12,
  parameter int SCROLL_LINE = 300
) (
  input  logic                     clk,
  input  logic                     rst,
  doodle_landing_detector_if.slave bus
`ifdef LANDING_STATS_EN
  ,
  output logic [15:0]              landing_count
`endif
);

  localparam int IDX_W = $clog2(N_PLATFORMS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PLATFORMS);
  localparam logic signed [12:0] DH = 13'(DOODLE_H);
  localparam logic signed [12:0] DW = 13'(DOODLE_W);
  localparam logic signed [12:0] PW = 13'(PLATFORM_W);
  localparam logic signed [12:0] LT = 13'(LAND_TOL);
  localparam logic signed [12:0] SL = 13'(SCROLL_LINE);

  if (CLK / FPS <= N_PLATFORMS + 4) begin : g_frame_chk
    $error("doodle_landing_detector: CLK/FPS must exceed N_PLATFORMS+4");
  end
  if (N_PLATFORMS > 128) begin : g_idx_chk
    $error("doodle_landing_detector: hit_index is 7 bits, N_PLATFORMS <= 128");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_n;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] sel;
  logic tick, issue, hit_c;
  logic [10:0] snap_x;
  logic [9:0] snap_y;
  logic snap_fall;
  logic signed [12:0] plat_y_w, plat_x_w, feet_w, dx_w;

  logic vld_p1, hit_p1;
  logic [6:0] idx_p1;
  logic signed [10:0] y_p1;
  logic found_p2;
  logic [6:0] hit_idx_p2;
  logic signed [10:0] hit_y_p2;

  logic landed_r, move_r;
  logic [6:0] hit_index_r;
  logic signed [10:0] land_y_r;

  assign tick = &bus.fps_counter;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // FSM next state; SCAN includes one drain cycle once index reaches N
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tick) state_n = SCAN;
      SCAN:    if (index == LAST_IDX) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stage 0: slot select and hit condition in 13-bit signed arithmetic
  always_comb begin
    issue    = (state == SCAN) && (index < LAST_IDX);
    sel      = issue ? index : '0;
    plat_y_w = 13'($signed(bus.platforms[sel][0]));
    plat_x_w = 13'($signed(bus.platforms[sel][1]));
    feet_w   = $signed({3'b000, snap_y}) + DH;
    dx_w     = $signed({2'b00, snap_x});
    hit_c    = bus.platform_activation[sel] && snap_fall &&
               (plat_y_w <= feet_w) && (feet_w < plat_y_w + LT) &&
               (dx_w + DW > plat_x_w) && (dx_w < plat_x_w + PW);
  end

  // Control: scan index, stage valid, found flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index    <= '0;
      vld_p1   <= 1'b0;
      found_p2 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (state == IDLE && tick) begin
        index    <= '0;
        found_p2 <= 1'b0;
      end else begin
        if (issue) index <= index + 1'b1;
        if (vld_p1 && hit_p1) found_p2 <= 1'b1;
      end
    end
  end

  // Datapath: snapshot, stage 1 hit register, stage 2 first-hit capture
  always_ff @(posedge clk) begin
    if (state == IDLE && tick) begin
      snap_x    <= bus.doodle_x;
      snap_y    <= bus.doodle_y;
      snap_fall <= bus.doodle_falling;
    end
    // stage 1
    hit_p1 <= hit_c;
    idx_p1 <= 7'(sel);
    y_p1   <= $signed(bus.platforms[sel][0]);
    // stage 2
    if (vld_p1 && hit_p1 && !found_p2) begin
      hit_idx_p2 <= idx_p1;
      hit_y_p2   <= y_p1;
    end
  end

  // Result registers, loaded in DONE; held until the next DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      landed_r    <= 1'b0;
      hit_index_r <= '0;
      land_y_r    <= '0;
      move_r      <= 1'b0;
    end else if (state == DONE) begin
      landed_r <= found_p2;
      move_r   <= found_p2 && (13'(hit_y_p2) < SL);
      if (found_p2) begin
        hit_index_r <= hit_idx_p2;
        land_y_r    <= hit_y_p2;
      end
    end
  end

`ifdef LANDING_STATS_EN
  // Saturating count of frames that found a landing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) landing_count <= '0;
    else if (state == DONE && found_p2 && landing_count != 16'hFFFF)
      landing_count <= landing_count + 16'd1;
  end
`endif

  assign bus.busy           = (state != IDLE);
  assign bus.landed         = landed_r;
  assign bus.hit_index      = hit_index_r;
  assign bus.land_y         = land_y_r;
  assign bus.move_collision = move_r;

endmodule

// File: tb/tb_doodle_landing_detector.sv
// Testbench for doodle_landing_detector: per-scenario tasks, scoreboard
// queue of expected frame results filled when a tick is issued.
module tb_doodle_landing_detector;
  localparam int N     = 93;
  localparam int FC_W  = $clog2(50_000_000 / 60) + 1;
  localparam int LIMIT = 300;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  doodle_landing_detector_if #(.N_PLATFORMS(N), .FC_W(FC_W)) bus ();
`ifdef LANDING_STATS_EN
  logic [15:0] landing_count;
`endif

  doodle_landing_detector #(.N_PLATFORMS(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef LANDING_STATS_EN
    ,
    .landing_count(landing_count)
`endif
  );

  typedef struct {
    logic              landed;
    logic [6:0]        idx;
    logic signed [10:0] y;
    logic              mc;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int py[N];
  int px[N];
  bit act[N];
  int prev_idx = 0;
  int prev_y = 0;
  int exp_lands = 0;

  task automatic clear_field();
    for (int i = 0; i < N; i++) begin
      py[i] = 0; px[i] = 0; act[i] = 0;
    end
    bus.platforms = '0;
    bus.platform_activation = '0;
  endtask

  task automatic set_plat(input int i, input int y, input int x, input bit a);
    py[i] = y; px[i] = x; act[i] = a;
    bus.platforms[i][0] = 11'(y);
    bus.platforms[i][1] = 11'(x);
    bus.platform_activation[i] = a;
  endtask

  task automatic pulse_tick();
    bus.fps_counter = '1;
    @(posedge clk); #1;
    bus.fps_counter = '0;
  endtask

  // Push the modelled result, issue one frame, wait (bounded) for the scan end
  task automatic do_frame(input int dx, input int dy, input bit fall, output int n);
    exp_t e;
    int hit;
    hit = -1;
    for (int i = 0; i < N; i++) begin
      if (hit < 0 && act[i] && fall && py[i] <= dy + 80 && dy + 80 < py[i] + 12 &&
          dx + 80 > px[i] && dx < px[i] + 100) hit = i;
    end
    if (hit >= 0) begin
      prev_idx = hit; prev_y = py[hit]; exp_lands++;
    end
    e.landed = (hit >= 0);
    e.idx    = 7'(prev_idx);
    e.y      = 11'(prev_y);
    e.mc     = (hit >= 0) && (prev_y < 300);
    sb.push_back(e);
    bus.doodle_x = 11'(dx);
    bus.doodle_y = 10'(dy);
    bus.doodle_falling = fall;
    pulse_tick();
    n = 0;
    while (bus.busy && n < LIMIT) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= LIMIT) begin
      checks++; errors++;
      $display("FAIL scan_timeout: busy still high after %0d cycles, required low", n);
    end
  endtask

  task automatic test_reset();
    bus.fps_counter = '0;
    bus.doodle_x = '0; bus.doodle_y = '0; bus.doodle_falling = 1'b0;
    clear_field();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.landed, bus.hit_index, bus.land_y, bus.move_collision} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b landed=%b idx=%0d y=%0d mc=%b, required all 0",
               bus.busy, bus.landed, bus.hit_index, bus.land_y, bus.move_collision);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    exp_t e;
    int n;
    clear_field();
    set_plat(5, 400, 342, 1);
    do_frame(360, 322, 1, n);
    checks++;
    if (n !== 95) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d cycles, required 95", n);
    end
    e = sb.pop_front();
    checks++;
    if ({bus.landed, bus.hit_index, bus.land_y, bus.move_collision} !== {e.landed, e.idx, e.y, e.mc}) begin
      errors++;
      $display("FAIL basic_result: got landed=%b idx=%0d y=%0d mc=%b, required landed=%b idx=%0d y=%0d mc=%b",
               bus.landed, bus.hit_index, bus.land_y, bus.move_collision, e.landed, e.idx, e.y, e.mc);
    end
  endtask

  task automatic test_scroll();
    exp_t e;
    int n;
    clear_field();
    set_plat(5, 250, 342, 1);
    do_frame(360, 172, 1, n);
    e = sb.pop_front();
    checks++;
    if ({bus.landed, bus.hit_index, bus.land_y, bus.move_collision} !== {e.landed, e.idx, e.y, e.mc}) begin
      errors++;
      $display("FAIL scroll_result: got landed=%b idx=%0d y=%0d mc=%b, required landed=%b idx=%0d y=%0d mc=%b",
               bus.landed, bus.hit_index, bus.land_y, bus.move_collision, e.landed, e.idx, e.y, e.mc);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (bus.move_collision !== 1'b1) begin
      errors++;
      $display("FAIL scroll_hold: got move_collision=%b, required 1", bus.move_collision);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    int n;
    clear_field();
    set_plat(3, 400, 342, 1);
    set_plat(40, 400, 342, 1);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) set_plat(3, 400, 342, 0);
      do_frame(360, 322, (k != 2), n);
      e = sb.pop_front();
      checks++;
      if ({bus.landed, bus.hit_index, bus.land_y, bus.move_collision} !== {e.landed, e.idx, e.y, e.mc}) begin
        errors++;
        $display("FAIL priority_%0d: got landed=%b idx=%0d y=%0d mc=%b, required landed=%b idx=%0d y=%0d mc=%b",
                 k, bus.landed, bus.hit_index, bus.land_y, bus.move_collision, e.landed, e.idx, e.y, e.mc);
      end
    end
  endtask

  task automatic test_edges();
    exp_t e;
    int n;
    int dxs[6] = '{360, 360, 262, 263, 360, 360};
    int dys[6] = '{332, 331, 322, 322, 322, 0};
    clear_field();
    set_plat(5, 400, 342, 1);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) set_plat(5, 401, 342, 1);
      if (k == 5) set_plat(5, -10, 342, 1);
      do_frame(dxs[k], dys[k], 1, n);
      e = sb.pop_front();
      checks++;
      if ({bus.landed, bus.hit_index, bus.land_y, bus.move_collision} !== {e.landed, e.idx, e.y, e.mc}) begin
        errors++;
        $display("FAIL edge_%0d: got landed=%b idx=%0d y=%0d mc=%b, required landed=%b idx=%0d y=%0d mc=%b",
                 k, bus.landed, bus.hit_index, bus.land_y, bus.move_collision, e.landed, e.idx, e.y, e.mc);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    int n;
    bit bad;
    clear_field();
    set_plat(7, 400, 342, 1);
    bus.doodle_x = 11'd360; bus.doodle_y = 10'd322; bus.doodle_falling = 1'b1;
    pulse_tick();
    repeat (38) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.landed, bus.hit_index, bus.land_y, bus.move_collision} !== 21'd0) begin
      errors++;
      $display("FAIL midscan_reset: got busy=%b landed=%b idx=%0d y=%0d mc=%b, required all 0",
               bus.busy, bus.landed, bus.hit_index, bus.land_y, bus.move_collision);
    end
    prev_idx = 0; prev_y = 0; exp_lands = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < N + 10; c++) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b0 || bus.landed !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midscan_no_done: got activity after reset, required busy=0 landed=0");
    end
    do_frame(360, 322, 1, n);
    e = sb.pop_front();
    checks++;
    if ({bus.landed, bus.hit_index, bus.land_y, bus.move_collision} !== {e.landed, e.idx, e.y, e.mc}) begin
      errors++;
      $display("FAIL midscan_next: got landed=%b idx=%0d y=%0d mc=%b, required landed=%b idx=%0d y=%0d mc=%b",
               bus.landed, bus.hit_index, bus.land_y, bus.move_collision, e.landed, e.idx, e.y, e.mc);
    end
  endtask

`ifdef LANDING_STATS_EN
  task automatic test_stats();
    exp_t e;
    int n;
    @(posedge clk); #2;
    rst = 1'b0;
    prev_idx = 0; prev_y = 0; exp_lands = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_field();
    set_plat(9, 400, 342, 1);
    for (int k = 0; k < 4; k++) begin
      do_frame(360, (k == 2) ? 0 : 322, 1, n);
      e = sb.pop_front();
      checks++;
      if ({bus.landed, bus.hit_index, bus.land_y, bus.move_collision} !== {e.landed, e.idx, e.y, e.mc}) begin
        errors++;
        $display("FAIL stats_frame_%0d: got landed=%b idx=%0d, required landed=%b idx=%0d",
                 k, bus.landed, bus.hit_index, e.landed, e.idx);
      end
    end
    checks++;
    if (landing_count !== 16'(exp_lands)) begin
      errors++;
      $display("FAIL stats_count: got %0d, required %0d", landing_count, exp_lands);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_scroll();
    test_priority();
    test_edges();
    test_reset_mid_scan();
`ifdef LANDING_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/doodle_landing_detector.md
# doodle_landing_detector

Per-frame collision scanner between the doodle and the platform field. On every frame tick it walks the platform position/activation arrays one entry per clock and finds the first active platform the falling doodle's feet have landed on. It produces the registered `move_collision` level that the platform block samples on the next tick to scroll the field, plus landing data for the doodle physics block.

## Interface
Parameters:
- `FPS`, 60: frame rate.
- `CLK`, 50_000_000: clock frequency in Hz.
- `N_PLATFORMS`, 93: number of platform slots.
- `PLATFORM_W`, 100: platform width in px.
- `DOODLE_W`, 80: doodle width in px.
- `DOODLE_H`, 80: doodle height in px.
- `LAND_TOL`, 12: vertical landing window in px. Equals the per-frame scroll step.
- `SCROLL_LINE`, 300: screen y; landings above this line request a scroll.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `fps_counter` in `$clog2(CLK/FPS)+1`: frame counter. Tick = all ones.
- `platforms` in `[N_PLATFORMS-1:0][1:0][10:0]` signed: `[i][0]` is top y, `[i][1]` is left x.
- `platform_activation` in `N_PLATFORMS`: slot i is live.
- `doodle_x` in 11: doodle left x.
- `doodle_y` in 10: doodle top y.
- `doodle_falling` in 1: vertical velocity is downward.
- `move_collision` out 1: scroll request. Level, held for one frame.
- `landed` out 1: a landing was found in the last scan.
- `hit_index` out 7: slot of the landed platform.
- `land_y` out 11 signed: top y of the landed platform.
- `busy` out 1: scan in progress.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE, on tick:**
  - Snapshot `doodle_x`, `doodle_y`, `doodle_falling`.
  - Clear the internal found flag.
  - Set index to 0, go to SCAN, assert `busy`.
- **SCAN:** each cycle, compare stage 1 reads slot `index` and registers the hit flag. Stage 2 accepts the hit only if no earlier hit was found, so the lowest index wins. `index` increments each cycle. After index `N_PLATFORMS-1` is issued, go to DONE.
- **Hit condition**, all terms must hold. Arithmetic is 13-bit signed; `doodle_y` is zero-extended and `doodle_x` is zero-extended.
  - activation is 1;
  - snapshot falling is 1;
  - `plat_y <= doodle_y + DOODLE_H < plat_y + LAND_TOL`;
  - `doodle_x + DOODLE_W > plat_x`;
  - `doodle_x < plat_x + PLATFORM_W`.
- **DONE:** takes one cycle, then return to IDLE with `busy` low. In that cycle:
  - `landed` takes the found flag.
  - If found, load `hit_index` and `land_y`.
  - `move_collision` is set to `found && land_y < SCROLL_LINE`, signed compare.
  - With no hit, `hit_index` and `land_y` keep their old values.
- A tick arriving while `busy` is ignored. With legal parameters this cannot occur.
- Platforms with negative y (off-screen above) are compared normally.
- Reset, including mid-scan:
  - FSM goes to IDLE;
  - all outputs go to 0;
  - the found flag is cleared.

## Timing
- Tick seen at cycle T.
- SCAN occupies T+1 .. T+N_PLATFORMS.
- Pipeline drain at T+N_PLATFORMS+1.
- DONE at T+N_PLATFORMS+2; outputs visible from T+N_PLATFORMS+3.
- Outputs are stable until the next scan's DONE, so the platform block samples `move_collision` at the following tick.
- End-to-end latency: one frame.
- Requirement: `CLK/FPS > N_PLATFORMS + 4`. Check this with an elaboration-time assertion.
- Platform arrays update on the tick cycle itself and are stable from T+1, so the scan sees post-scroll positions.

## Configuration
- Macro `LANDING_STATS_EN`:
  - **Defined:** adds output `landing_count` (16 bits). It is reset to 0, increments in DONE when found, and saturates at 0xFFFF.
  - **Undefined:** the port and counter are absent and behaviour is otherwise identical.

## Test plan
- **Basic landing.** Slot 5 at y=400, x=342, active; doodle x=360, y=322, falling; tick. Expect:
  - `busy` high for 95 cycles;
  - `landed`=1, `hit_index`=5, `land_y`=400, `move_collision`=0 (400 ≥ 300).
- **Scroll request.** Same as basic landing with the platform at y=250 and doodle y=172. Expect `move_collision`=1, held until the next DONE.
- **Priority and gating.**
  - Slots 3 and 40 both satisfy the hit condition: expect `hit_index`=3.
  - Slot 3 deactivated: expect `hit_index`=40.
  - `doodle_falling`=0: expect `landed`=0.
- **Edges.**
  - Feet at exactly `plat_y+LAND_TOL`: miss. Feet at `plat_y+LAND_TOL-1`: hit.
  - `doodle_x+DOODLE_W == plat_x`: miss.
  - Platform y=-10: no hit and no overflow.
- **Reset mid-scan.** Assert `rst` low at T+40. Expect:
  - all outputs 0 immediately (asynchronous);
  - no DONE occurs;
  - the next tick after release scans normally.
- **Stats (`LANDING_STATS_EN`).** Three landing frames and one miss frame: expect `landing_count`=3.
